// File: rtl/pkt_buffer_wr_ctrl_if.sv
// Bus bundle between the ingress stream, address manager, data RAM and scheduler
// and the packet-buffer write controller.
interface pkt_buffer_wr_ctrl_if #(
    parameter int unsigned DATA_WIDTH  = 256,
    parameter int unsigned KEEP_WIDTH  = 32,
    parameter int unsigned TUSER_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH  = 12
);
    localparam int unsigned WR_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1;

    logic [DATA_WIDTH-1:0]  s_axis_tdata;
    logic [KEEP_WIDTH-1:0]  s_axis_tkeep;
    logic [TUSER_WIDTH-1:0] s_axis_tuser;
    logic                   s_axis_tlast;
    logic                   s_axis_tvalid;
    logic                   s_axis_tready;
    logic [ADDR_WIDTH-1:0]  s_axis_fl_head;
    logic                   s_axis_almost_full;
    logic                   m_axis_wr_en;
    logic                   m_axis_buf_wr_en;
    logic [ADDR_WIDTH-1:0]  m_axis_buf_wr_addr;
    logic [WR_WIDTH-1:0]    m_axis_buf_wr_data;
    logic                   m_axis_desc_valid;
    logic                   m_axis_desc_ready;
    logic [ADDR_WIDTH-1:0]  m_axis_desc_start_addr;
    logic [ADDR_WIDTH-1:0]  m_axis_desc_len;
    logic [TUSER_WIDTH-1:0] m_axis_desc_tuser;
    logic                   m_axis_desc_err;
    logic [31:0]            m_axis_pkt_cnt;
    logic [31:0]            m_axis_drop_cnt;

    // Controller view
    modport master (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast, s_axis_tvalid,
        input  s_axis_fl_head, s_axis_almost_full, m_axis_desc_ready,
        output s_axis_tready, m_axis_wr_en, m_axis_buf_wr_en, m_axis_buf_wr_addr,
        output m_axis_buf_wr_data, m_axis_desc_valid, m_axis_desc_start_addr,
        output m_axis_desc_len, m_axis_desc_tuser, m_axis_desc_err,
        output m_axis_pkt_cnt, m_axis_drop_cnt
    );

    // Environment view
    modport slave (
        output s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast, s_axis_tvalid,
        output s_axis_fl_head, s_axis_almost_full, m_axis_desc_ready,
        input  s_axis_tready, m_axis_wr_en, m_axis_buf_wr_en, m_axis_buf_wr_addr,
        input  m_axis_buf_wr_data, m_axis_desc_valid, m_axis_desc_start_addr,
        input  m_axis_desc_len, m_axis_desc_tuser, m_axis_desc_err,
        input  m_axis_pkt_cnt, m_axis_drop_cnt
    );
endinterface

// File: rtl/pkt_buffer_wr_ctrl.sv
// Packet-buffer write controller: stores stream words at free-list head addresses,
// emits one descriptor per packet, drops whole packets at SOP when almost full.
module pkt_buffer_wr_ctrl #(
    parameter int unsigned DATA_WIDTH    = 256,
    parameter int unsigned KEEP_WIDTH    = 32,
    parameter int unsigned TUSER_WIDTH   = 128,
    parameter int unsigned ADDR_WIDTH    = 12,
    parameter int unsigned MAX_PKT_WORDS = 48
) (
    input  logic                   clk,
    input  logic                   rstn,
    pkt_buffer_wr_ctrl_if.master   bus
);
    localparam int unsigned WR_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, WRITE, DROP, DESC_WAIT} state_t;

    state_t                 state, state_nx;
    logic                   tready;
    logic                   trunc;
    logic                   desc_valid;
    logic [ADDR_WIDTH-1:0]  start_addr;
    logic [ADDR_WIDTH-1:0]  len;
    logic [TUSER_WIDTH-1:0] tuser;
    logic                   err;
    logic [31:0]            pkt_cnt;
    logic [31:0]            drop_cnt;

    logic accept_c, store_c, sop_ld_c, len_inc_c, trunc_set_c, drop_hit_c, desc_done_c;

    assign accept_c = bus.s_axis_tvalid & tready;

    // Next-state and per-beat decisions
    always_comb begin
        state_nx    = state;
        store_c     = 1'b0;
        sop_ld_c    = 1'b0;
        len_inc_c   = 1'b0;
        trunc_set_c = 1'b0;
        drop_hit_c  = 1'b0;
        desc_done_c = 1'b0;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    if (bus.s_axis_almost_full) begin
                        drop_hit_c = 1'b1;
                        if (!bus.s_axis_tlast) state_nx = DROP;
                    end else begin
                        store_c  = 1'b1;
                        sop_ld_c = 1'b1;
                        if (bus.s_axis_tlast) begin
                            state_nx = DESC_WAIT;
                        end else if (MAX_PKT_WORDS == 1) begin
                            trunc_set_c = 1'b1;
                            state_nx    = DROP;
                        end else begin
                            state_nx = WRITE;
                        end
                    end
                end
            end
            WRITE: begin
                if (accept_c) begin
                    store_c   = 1'b1;
                    len_inc_c = 1'b1;
                    if (bus.s_axis_tlast) begin
                        state_nx = DESC_WAIT;
                    end else if (len == ADDR_WIDTH'(MAX_PKT_WORDS - 1)) begin
                        trunc_set_c = 1'b1;
                        state_nx    = DROP;
                    end
                end
            end
            DROP: begin
                if (accept_c && bus.s_axis_tlast) state_nx = trunc ? DESC_WAIT : IDLE;
            end
            DESC_WAIT: begin
                if (bus.m_axis_desc_ready) begin
                    desc_done_c = 1'b1;
                    state_nx    = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // tready is a registered decode so it is low throughout reset and in DESC_WAIT
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            tready     <= 1'b0;
            trunc      <= 1'b0;
            desc_valid <= 1'b0;
            start_addr <= '0;
            len        <= '0;
            tuser      <= '0;
            err        <= 1'b0;
            pkt_cnt    <= '0;
            drop_cnt   <= '0;
        end else begin
            state      <= state_nx;
            tready     <= (state_nx != DESC_WAIT);
            desc_valid <= (state_nx == DESC_WAIT);
            if (sop_ld_c) begin
                start_addr <= bus.s_axis_fl_head;
                tuser      <= bus.s_axis_tuser;
                len        <= ADDR_WIDTH'(1);
                err        <= 1'b0;
            end
            if (len_inc_c)   len      <= len + ADDR_WIDTH'(1);
            if (trunc_set_c) begin
                err   <= 1'b1;
                trunc <= 1'b1;
            end
            if (desc_done_c) trunc    <= 1'b0;
            if (desc_done_c) pkt_cnt  <= pkt_cnt + 32'd1;
            if (drop_hit_c)  drop_cnt <= drop_cnt + 32'd1;
        end
    end

    // Write path is combinational so consecutive beats hit consecutive free-list entries
    assign bus.m_axis_wr_en       = store_c;
    assign bus.m_axis_buf_wr_en   = store_c;
    assign bus.m_axis_buf_wr_addr = bus.s_axis_fl_head;
    assign bus.m_axis_buf_wr_data = WR_WIDTH'({bus.s_axis_tlast, bus.s_axis_tkeep, bus.s_axis_tdata});

    assign bus.s_axis_tready          = tready;
    assign bus.m_axis_desc_valid      = desc_valid;
    assign bus.m_axis_desc_start_addr = start_addr;
    assign bus.m_axis_desc_len        = len;
    assign bus.m_axis_desc_tuser      = tuser;
    assign bus.m_axis_desc_err        = err;
    assign bus.m_axis_pkt_cnt         = pkt_cnt;
    assign bus.m_axis_drop_cnt        = drop_cnt;
endmodule

// File: tb/tb_pkt_buffer_wr_ctrl.sv
// Directed bench for pkt_buffer_wr_ctrl: inputs change on the falling edge,
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_pkt_buffer_wr_ctrl;
    localparam int unsigned DW = 256, KW = 32, UW = 128, AW = 12, MAXW = 48;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pkt_buffer_wr_ctrl_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TUSER_WIDTH(UW), .ADDR_WIDTH(AW)) bus ();

    pkt_buffer_wr_ctrl #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TUSER_WIDTH(UW),
                         .ADDR_WIDTH(AW), .MAX_PKT_WORDS(MAXW)) dut (
        .clk(clk), .rstn(rstn), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic drive(input logic [DW-1:0] d, input logic last, input logic [AW-1:0] head,
                         input logic af, input logic [UW-1:0] u);
        bus.s_axis_tvalid      = 1'b1;
        bus.s_axis_tdata       = d;
        bus.s_axis_tkeep       = '1;
        bus.s_axis_tlast       = last;
        bus.s_axis_fl_head     = head;
        bus.s_axis_almost_full = af;
        bus.s_axis_tuser       = u;
    endtask

    task automatic test_reset();
        bus.s_axis_tvalid = 1'b0; bus.s_axis_tdata = '0; bus.s_axis_tkeep = '0;
        bus.s_axis_tlast = 1'b0; bus.s_axis_tuser = '0; bus.s_axis_fl_head = '0;
        bus.s_axis_almost_full = 1'b0; bus.m_axis_desc_ready = 1'b1;
        #2;
        checks++; if (bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b expected 0", bus.s_axis_tready); end
        checks++; if (bus.m_axis_wr_en !== 1'b0 || bus.m_axis_buf_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b/%b expected 0/0", bus.m_axis_wr_en, bus.m_axis_buf_wr_en); end
        checks++; if (bus.m_axis_desc_valid !== 1'b0 || bus.m_axis_desc_len !== '0 || bus.m_axis_desc_start_addr !== '0 || bus.m_axis_desc_err !== 1'b0 || bus.m_axis_desc_tuser !== '0) begin errors++; $display("FAIL reset_desc: got valid=%b len=%0d start=%0d err=%b expected all 0", bus.m_axis_desc_valid, bus.m_axis_desc_len, bus.m_axis_desc_start_addr, bus.m_axis_desc_err); end
        checks++; if (bus.m_axis_pkt_cnt !== 32'd0 || bus.m_axis_drop_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got pkt=%0d drop=%0d expected 0/0", bus.m_axis_pkt_cnt, bus.m_axis_drop_cnt); end
        repeat (2) @(posedge clk);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_single(input logic [31:0] exp_pkt);
        logic [DW+KW:0] exp;
        logic [DW-1:0]  d;
        logic [UW-1:0]  u;
        d = {8{32'h1111_0001}};
        u = {4{32'hCAFE_0001}};
        @(negedge clk); drive(d, 1'b1, 12'd0, 1'b0, u); #1;
        exp = {1'b1, {KW{1'b1}}, d};
        checks++; if (bus.s_axis_tready !== 1'b1) begin errors++; $display("FAIL single_tready_accept: got %b expected 1", bus.s_axis_tready); end
        checks++; if (bus.m_axis_wr_en !== 1'b1 || bus.m_axis_buf_wr_en !== 1'b1) begin errors++; $display("FAIL single_wr_en: got %b/%b expected 1/1", bus.m_axis_wr_en, bus.m_axis_buf_wr_en); end
        checks++; if (bus.m_axis_buf_wr_addr !== 12'd0) begin errors++; $display("FAIL single_addr: got %0d expected 0", bus.m_axis_buf_wr_addr); end
        checks++; if (bus.m_axis_buf_wr_data !== exp) begin errors++; $display("FAIL single_data: got %h expected %h", bus.m_axis_buf_wr_data, exp); end
        @(negedge clk); bus.s_axis_tvalid = 1'b0; #1;
        checks++; if (bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL single_tready_bubble: got %b expected 0", bus.s_axis_tready); end
        checks++; if (bus.m_axis_wr_en !== 1'b0) begin errors++; $display("FAIL single_wr_en_once: got %b expected 0", bus.m_axis_wr_en); end
        checks++; if (bus.m_axis_desc_valid !== 1'b1 || bus.m_axis_desc_start_addr !== 12'd0 || bus.m_axis_desc_len !== 12'd1 || bus.m_axis_desc_err !== 1'b0) begin errors++; $display("FAIL single_desc: got v=%b start=%0d len=%0d err=%b expected 1/0/1/0", bus.m_axis_desc_valid, bus.m_axis_desc_start_addr, bus.m_axis_desc_len, bus.m_axis_desc_err); end
        checks++; if (bus.m_axis_desc_tuser !== u) begin errors++; $display("FAIL single_tuser: got %h expected %h", bus.m_axis_desc_tuser, u); end
        @(negedge clk); #1;
        checks++; if (bus.s_axis_tready !== 1'b1 || bus.m_axis_desc_valid !== 1'b0) begin errors++; $display("FAIL single_after: got tready=%b valid=%b expected 1/0", bus.s_axis_tready, bus.m_axis_desc_valid); end
        checks++; if (bus.m_axis_pkt_cnt !== exp_pkt) begin errors++; $display("FAIL single_pkt_cnt: got %0d expected %0d", bus.m_axis_pkt_cnt, exp_pkt); end
    endtask

    task automatic test_multi();
        logic [AW-1:0] heads [4];
        logic [UW-1:0] u;
        heads = '{12'd5, 12'd9, 12'd2, 12'd7};
        u = {4{32'hBEEF_0002}};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive({8{32'h2222_0000 + 32'(i)}}, i == 3, heads[i], 1'b0, (i == 0) ? u : '1); #1;
            checks++; if (bus.m_axis_buf_wr_en !== 1'b1 || bus.m_axis_buf_wr_addr !== heads[i] || bus.s_axis_tready !== 1'b1) begin errors++; $display("FAIL multi_write[%0d]: got en=%b addr=%0d rdy=%b expected 1/%0d/1", i, bus.m_axis_buf_wr_en, bus.m_axis_buf_wr_addr, bus.s_axis_tready, heads[i]); end
        end
        @(negedge clk); bus.s_axis_tvalid = 1'b0; #1;
        checks++; if (bus.m_axis_desc_valid !== 1'b1 || bus.m_axis_desc_start_addr !== 12'd5 || bus.m_axis_desc_len !== 12'd4 || bus.m_axis_desc_err !== 1'b0) begin errors++; $display("FAIL multi_desc: got v=%b start=%0d len=%0d err=%b expected 1/5/4/0", bus.m_axis_desc_valid, bus.m_axis_desc_start_addr, bus.m_axis_desc_len, bus.m_axis_desc_err); end
        checks++; if (bus.m_axis_desc_tuser !== u) begin errors++; $display("FAIL multi_tuser: got %h expected %h", bus.m_axis_desc_tuser, u); end
        @(negedge clk); #1;
        checks++; if (bus.m_axis_pkt_cnt !== 32'd2) begin errors++; $display("FAIL multi_pkt_cnt: got %0d expected 2", bus.m_axis_pkt_cnt); end
    endtask

    task automatic test_drop();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive({8{32'h3333_0000 + 32'(i)}}, i == 2, 12'd15, 1'b1, '0); #1;
            checks++; if (bus.s_axis_tready !== 1'b1 || bus.m_axis_wr_en !== 1'b0 || bus.m_axis_buf_wr_en !== 1'b0) begin errors++; $display("FAIL drop_beat[%0d]: got rdy=%b wr=%b bwr=%b expected 1/0/0", i, bus.s_axis_tready, bus.m_axis_wr_en, bus.m_axis_buf_wr_en); end
        end
        @(negedge clk); bus.s_axis_tvalid = 1'b0; bus.s_axis_almost_full = 1'b0; #1;
        checks++; if (bus.m_axis_desc_valid !== 1'b0 || bus.s_axis_tready !== 1'b1) begin errors++; $display("FAIL drop_no_desc: got valid=%b rdy=%b expected 0/1", bus.m_axis_desc_valid, bus.s_axis_tready); end
        checks++; if (bus.m_axis_drop_cnt !== 32'd1 || bus.m_axis_pkt_cnt !== 32'd2) begin errors++; $display("FAIL drop_cnt: got drop=%0d pkt=%0d expected 1/2", bus.m_axis_drop_cnt, bus.m_axis_pkt_cnt); end
        // almost_full rising after SOP must not affect the packet
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive({8{32'h4444_0000 + 32'(i)}}, i == 2, 12'(20 + i), i != 0, '0); #1;
            checks++; if (bus.m_axis_wr_en !== 1'b1 || bus.m_axis_buf_wr_addr !== 12'(20 + i)) begin errors++; $display("FAIL af_mid_write[%0d]: got en=%b addr=%0d expected 1/%0d", i, bus.m_axis_wr_en, bus.m_axis_buf_wr_addr, 20 + i); end
        end
        @(negedge clk); bus.s_axis_tvalid = 1'b0; bus.s_axis_almost_full = 1'b0; #1;
        checks++; if (bus.m_axis_desc_valid !== 1'b1 || bus.m_axis_desc_start_addr !== 12'd20 || bus.m_axis_desc_len !== 12'd3 || bus.m_axis_desc_err !== 1'b0) begin errors++; $display("FAIL af_mid_desc: got v=%b start=%0d len=%0d err=%b expected 1/20/3/0", bus.m_axis_desc_valid, bus.m_axis_desc_start_addr, bus.m_axis_desc_len, bus.m_axis_desc_err); end
        @(negedge clk); #1;
        checks++; if (bus.m_axis_pkt_cnt !== 32'd3 || bus.m_axis_drop_cnt !== 32'd1) begin errors++; $display("FAIL af_mid_cnt: got pkt=%0d drop=%0d expected 3/1", bus.m_axis_pkt_cnt, bus.m_axis_drop_cnt); end
    endtask

    task automatic test_back_to_back();
        bus.m_axis_desc_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive({8{32'h5555_0000 + 32'(i)}}, i == 1, 12'(30 + i), 1'b0, {4{32'h0000_0005}}); #1;
            checks++; if (bus.m_axis_wr_en !== 1'b1 || bus.m_axis_buf_wr_addr !== 12'(30 + i)) begin errors++; $display("FAIL bp_write[%0d]: got en=%b addr=%0d expected 1/%0d", i, bus.m_axis_wr_en, bus.m_axis_buf_wr_addr, 30 + i); end
        end
        // next packet is already offered while the descriptor is stalled
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); drive({8{32'h6666_0000}}, 1'b1, 12'd40, 1'b0, {4{32'h0000_0006}}); #1;
            checks++; if (bus.s_axis_tready !== 1'b0 || bus.m_axis_wr_en !== 1'b0) begin errors++; $display("FAIL bp_stall[%0d]: got rdy=%b wr=%b expected 0/0", k, bus.s_axis_tready, bus.m_axis_wr_en); end
            checks++; if (bus.m_axis_desc_valid !== 1'b1 || bus.m_axis_desc_start_addr !== 12'd30 || bus.m_axis_desc_len !== 12'd2) begin errors++; $display("FAIL bp_desc_stable[%0d]: got v=%b start=%0d len=%0d expected 1/30/2", k, bus.m_axis_desc_valid, bus.m_axis_desc_start_addr, bus.m_axis_desc_len); end
            if (k == 9) bus.m_axis_desc_ready = 1'b1;
        end
        @(negedge clk); #1;
        checks++; if (bus.s_axis_tready !== 1'b1 || bus.m_axis_wr_en !== 1'b1 || bus.m_axis_buf_wr_addr !== 12'd40) begin errors++; $display("FAIL bp_next_accept: got rdy=%b wr=%b addr=%0d expected 1/1/40", bus.s_axis_tready, bus.m_axis_wr_en, bus.m_axis_buf_wr_addr); end
        checks++; if (bus.m_axis_pkt_cnt !== 32'd4) begin errors++; $display("FAIL bp_pkt_cnt: got %0d expected 4", bus.m_axis_pkt_cnt); end
        @(negedge clk); bus.s_axis_tvalid = 1'b0; #1;
        checks++; if (bus.m_axis_desc_valid !== 1'b1 || bus.m_axis_desc_start_addr !== 12'd40 || bus.m_axis_desc_len !== 12'd1) begin errors++; $display("FAIL bp_next_desc: got v=%b start=%0d len=%0d expected 1/40/1", bus.m_axis_desc_valid, bus.m_axis_desc_start_addr, bus.m_axis_desc_len); end
        @(negedge clk);
    endtask

    task automatic test_truncate();
        int writes;
        writes = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); drive({8{32'h7777_0000 + 32'(i)}}, i == 59, 12'(100 + i), 1'b0, {4{32'h0000_0007}}); #1;
            if (bus.m_axis_buf_wr_en === 1'b1) writes++;
            checks++; if (bus.s_axis_tready !== 1'b1 || bus.m_axis_buf_wr_en !== (i < 48)) begin errors++; $display("FAIL trunc_beat[%0d]: got rdy=%b wr=%b expected 1/%0b", i, bus.s_axis_tready, bus.m_axis_buf_wr_en, i < 48); end
        end
        @(negedge clk); bus.s_axis_tvalid = 1'b0; #1;
        checks++; if (writes != 48) begin errors++; $display("FAIL trunc_writes: got %0d expected 48", writes); end
        checks++; if (bus.m_axis_desc_valid !== 1'b1 || bus.m_axis_desc_start_addr !== 12'd100 || bus.m_axis_desc_len !== 12'd48 || bus.m_axis_desc_err !== 1'b1) begin errors++; $display("FAIL trunc_desc: got v=%b start=%0d len=%0d err=%b expected 1/100/48/1", bus.m_axis_desc_valid, bus.m_axis_desc_start_addr, bus.m_axis_desc_len, bus.m_axis_desc_err); end
        @(negedge clk); #1;
        checks++; if (bus.m_axis_pkt_cnt !== 32'd6 || bus.s_axis_tready !== 1'b1) begin errors++; $display("FAIL trunc_after: got pkt=%0d rdy=%b expected 6/1", bus.m_axis_pkt_cnt, bus.s_axis_tready); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive({8{32'h8888_0000 + 32'(i)}}, 1'b0, 12'(200 + i), 1'b0, '0);
        end
        #2 rstn = 1'b0; #1;
        checks++; if (bus.s_axis_tready !== 1'b0 || bus.m_axis_wr_en !== 1'b0 || bus.m_axis_buf_wr_en !== 1'b0) begin errors++; $display("FAIL areset_outputs: got rdy=%b wr=%b bwr=%b expected 0/0/0", bus.s_axis_tready, bus.m_axis_wr_en, bus.m_axis_buf_wr_en); end
        checks++; if (bus.m_axis_desc_len !== '0 || bus.m_axis_desc_start_addr !== '0 || bus.m_axis_pkt_cnt !== 32'd0 || bus.m_axis_drop_cnt !== 32'd0) begin errors++; $display("FAIL areset_state: got len=%0d start=%0d pkt=%0d drop=%0d expected all 0", bus.m_axis_desc_len, bus.m_axis_desc_start_addr, bus.m_axis_pkt_cnt, bus.m_axis_drop_cnt); end
        @(negedge clk); bus.s_axis_tvalid = 1'b0; rstn = 1'b1;
        @(posedge clk);
        test_single(32'd1);
    endtask

    initial begin
        test_reset();
        test_single(32'd1);
        test_multi();
        test_drop();
        test_back_to_back();
        test_truncate();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
